// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared states, error codes and AXI constants for the GPU DMA blocks
package painterengine_gpu_pkg;

    // Bit 4 marks the error class so a single bit tells "failed" apart from progress states.
    typedef enum logic [4:0] {
        ST_ROUTING = 5'h00,
        ST_CHECK   = 5'h01,
        ST_CALC    = 5'h02,
        ST_ADDR    = 5'h03,
        ST_DATA    = 5'h04,
        ST_DRAIN   = 5'h05,
        ST_DONE    = 5'h06,
        ST_ERR     = 5'h10
    } dma_state_e;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ROUTER     = 3'd1;
    localparam logic [2:0] ERR_ALIGN      = 3'd2;
    localparam logic [2:0] ERR_LENGTH     = 3'd3;
    localparam logic [2:0] ERR_AR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_R_TIMEOUT  = 3'd5;
    localparam logic [2:0] ERR_RRESP      = 3'd6;
    localparam logic [2:0] ERR_RLAST      = 3'd7;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;

    localparam int DEFAULT_TIMEOUT = 256;

    // Index of the set bit of a one-hot router word (caller guarantees one-hot).
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// rtl/painterengine_gpu_sync_fifo.sv - show-ahead synchronous FIFO shared by the DMA reader and writer
module painterengine_gpu_sync_fifo
    import painterengine_gpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pop on empty is dropped; a push while full is accepted only when a pop frees the slot.
    always_comb begin
        do_pop   = i_pop && (count_q != '0);
        do_push  = i_push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty so it carries no reset.
    always_ff @(posedge i_clock) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// rtl/painterengine_gpu_dma_reader.sv - AXI4 read master feeding one of four GPU channels through a FIFO
module painterengine_gpu_dma_reader
    import painterengine_gpu_pkg::*;
#(
    parameter int PARAM_FIFO_DEPTH = 256,
    parameter int PARAM_MAX_BURST  = 256,
    parameter int PARAM_TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic          i_wire_clock,
    input  logic          i_wire_resetn,
    input  logic [3:0]    i_wire_router,
    output logic          o_wire_done,
    input  logic [127:0]  i_wire_address,
    input  logic [127:0]  i_wire_length,
    output logic [127:0]  o_wire_data,
    output logic [3:0]    o_wire_data_valid,
    input  logic [3:0]    i_wire_data_next,
    output logic          o_wire_error,
    output logic [2:0]    o_wire_error_type,
    output logic          o_wire_M_AXI_ARID,
    output logic [31:0]   o_wire_M_AXI_ARADDR,
    output logic [7:0]    o_wire_M_AXI_ARLEN,
    output logic [2:0]    o_wire_M_AXI_ARSIZE,
    output logic [1:0]    o_wire_M_AXI_ARBURST,
    output logic          o_wire_M_AXI_ARLOCK,
    output logic [3:0]    o_wire_M_AXI_ARCACHE,
    output logic [2:0]    o_wire_M_AXI_ARPROT,
    output logic [3:0]    o_wire_M_AXI_ARQOS,
    output logic          o_wire_M_AXI_ARVALID,
    input  logic          i_wire_M_AXI_ARREADY,
    input  logic          i_wire_M_AXI_RID,
    input  logic [31:0]   i_wire_M_AXI_RDATA,
    input  logic [1:0]    i_wire_M_AXI_RRESP,
    input  logic          i_wire_M_AXI_RLAST,
    input  logic          i_wire_M_AXI_RVALID,
    output logic          o_wire_M_AXI_RREADY
);

    localparam int CW = $clog2(PARAM_FIFO_DEPTH) + 1;
    localparam int TW = $clog2(PARAM_TIMEOUT + 1);

    dma_state_e  state_q, state_d;
    logic [1:0]  chan_q, chan_d;
    logic [31:0] addr_q, addr_d, len_q, len_d, offset_q, offset_d, araddr_q, araddr_d;
    logic [8:0]  beats_q, beats_d, beat_cnt_q, beat_cnt_d;
    logic        arvalid_q, arvalid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  err_type_q, err_type_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [31:0]   fifo_rdata;
    logic          out_valid, rready, r_beat, last_beat;
    logic [9:0]    fifo_free;
    logic [7:0]    unalign;
    logic [8:0]    room;
    logic [31:0]   remain;
    logic          unused_inputs;

    assign unused_inputs = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0], fifo_full};

    painterengine_gpu_sync_fifo #(.WIDTH(32), .DEPTH(PARAM_FIFO_DEPTH)) u_fifo (
        .i_clock  (i_wire_clock),
        .i_resetn (i_wire_resetn),
        .i_push   (fifo_push),
        .i_wdata  (i_wire_M_AXI_RDATA),
        .i_pop    (fifo_pop),
        .o_rdata  (fifo_rdata),
        .o_count  (fifo_count),
        .o_empty  (fifo_empty),
        .o_full   (fifo_full)
    );

    // Handshake qualifiers and burst-sizing arithmetic shared by the FSM.
    always_comb begin
        rready    = (state_q == ST_DATA);
        r_beat    = rready && i_wire_M_AXI_RVALID;
        fifo_push = r_beat;
        out_valid = !fifo_empty && (state_q != ST_ERR);
        fifo_pop  = out_valid && i_wire_data_next[chan_q];
        fifo_free = 10'(PARAM_FIFO_DEPTH) - 10'(fifo_count);
        last_beat = (beat_cnt_q == beats_q - 9'd1);
        unalign   = addr_q[9:2] + offset_q[7:0];
        room      = 9'd256 - {1'b0, unalign};
        remain    = len_q - offset_q;
    end

    // Transfer sequencing: route, validate, size bursts, issue AR, collect R, drain.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        addr_d     = addr_q;
        len_d      = len_q;
        offset_d   = offset_q;
        araddr_d   = araddr_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        arvalid_d  = arvalid_q;
        timer_d    = timer_q;
        err_type_d = err_type_q;
        case (state_q)
            ST_ROUTING: begin
                if (i_wire_router != 4'd0) begin
                    if ($onehot(i_wire_router)) begin
                        chan_d   = onehot_index(i_wire_router);
                        addr_d   = i_wire_address[{chan_d, 5'd0} +: 32];
                        len_d    = i_wire_length[{chan_d, 5'd0} +: 32];
                        offset_d = '0;
                        state_d  = ST_CHECK;
                    end else begin
                        err_type_d = ERR_ROUTER;
                        state_d    = ST_ERR;
                    end
                end
            end
            ST_CHECK: begin
                if (addr_q[1:0] != 2'b00) begin
                    err_type_d = ERR_ALIGN;
                    state_d    = ST_ERR;
                end else if (len_q == '0) begin
                    err_type_d = ERR_LENGTH;
                    state_d    = ST_ERR;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                beats_d = room;
                if (remain < 32'(room)) beats_d = remain[8:0];
                if (beats_d > 9'(PARAM_MAX_BURST)) beats_d = 9'(PARAM_MAX_BURST);
                araddr_d   = addr_q + {offset_q[29:0], 2'b00};
                beat_cnt_d = '0;
                state_d    = ST_ADDR;
            end
            ST_ADDR: begin
                if (!arvalid_q) begin
                    // Waiting for FIFO room is consumer backpressure, so it is not timed.
                    if (fifo_free >= {1'b0, beats_q}) begin
                        arvalid_d = 1'b1;
                        timer_d   = '0;
                    end
                end else if (i_wire_M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    timer_d   = '0;
                    state_d   = ST_DATA;
                end else if (timer_q == TW'(PARAM_TIMEOUT - 1)) begin
                    arvalid_d  = 1'b0;
                    err_type_d = ERR_AR_TIMEOUT;
                    state_d    = ST_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (r_beat) begin
                    timer_d = '0;
                    if (i_wire_M_AXI_RRESP[1]) begin
                        err_type_d = ERR_RRESP;
                        state_d    = ST_ERR;
                    end else if (i_wire_M_AXI_RLAST != last_beat) begin
                        err_type_d = ERR_RLAST;
                        state_d    = ST_ERR;
                    end else if (last_beat) begin
                        offset_d = offset_q + 32'(beats_q);
                        state_d  = (offset_d >= len_q) ? ST_DRAIN : ST_CALC;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end else if (timer_q == TW'(PARAM_TIMEOUT - 1)) begin
                    err_type_d = ERR_R_TIMEOUT;
                    state_d    = ST_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding transaction.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q    <= ST_ROUTING;
            chan_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            offset_q   <= '0;
            araddr_q   <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            arvalid_q  <= 1'b0;
            timer_q    <= '0;
            err_type_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            offset_q   <= offset_d;
            araddr_q   <= araddr_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            arvalid_q  <= arvalid_d;
            timer_q    <= timer_d;
            err_type_q <= err_type_d;
        end
    end

    // Consumer view: FIFO head on the active channel's slice only.
    always_comb begin
        o_wire_data       = '0;
        o_wire_data_valid = '0;
        if (out_valid) o_wire_data[{chan_q, 5'd0} +: 32] = fifo_rdata;
        o_wire_data_valid[chan_q] = out_valid;
    end

    assign o_wire_done          = (state_q == ST_DONE);
    assign o_wire_error         = (state_q == ST_ERR);
    assign o_wire_error_type    = err_type_q;
    assign o_wire_M_AXI_ARID    = 1'b0;
    assign o_wire_M_AXI_ARADDR  = arvalid_q ? araddr_q : '0;
    assign o_wire_M_AXI_ARLEN   = arvalid_q ? 8'(beats_q - 9'd1) : '0;
    assign o_wire_M_AXI_ARSIZE  = arvalid_q ? AXI_SIZE_4B : '0;
    assign o_wire_M_AXI_ARBURST = arvalid_q ? AXI_BURST_INCR : '0;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = arvalid_q ? AXI_CACHE_MOD : '0;
    assign o_wire_M_AXI_ARPROT  = '0;
    assign o_wire_M_AXI_ARQOS   = '0;
    assign o_wire_M_AXI_ARVALID = arvalid_q;
    assign o_wire_M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// tb/tb_painterengine_gpu_dma_reader.sv - directed self-checking bench for the GPU DMA reader
module tb_painterengine_gpu_dma_reader;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   router;
    logic         done;
    logic [127:0] address, length, data;
    logic [3:0]   valid, next;
    logic         error;
    logic [2:0]   etype;
    logic         arid, arlock, arvalid, arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst;
    logic [3:0]   arcache, arqos;
    logic         rid, rlast, rvalid, rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    logic [31:0] rx[$];
    int beat_k, beats_total, other_nz;
    int cur_ch = 0;
    bit ar_en = 1'b1;
    bit next_en = 1'b1;
    int rresp_bad_at = -1;
    int rlast_bad_at = -1;

    painterengine_gpu_dma_reader #(
        .PARAM_FIFO_DEPTH (16),
        .PARAM_MAX_BURST  (16),
        .PARAM_TIMEOUT    (256)
    ) dut (
        .i_wire_clock         (clk),
        .i_wire_resetn        (resetn),
        .i_wire_router        (router),
        .o_wire_done          (done),
        .i_wire_address       (address),
        .i_wire_length        (length),
        .o_wire_data          (data),
        .o_wire_data_valid    (valid),
        .i_wire_data_next     (next),
        .o_wire_error         (error),
        .o_wire_error_type    (etype),
        .o_wire_M_AXI_ARID    (arid),
        .o_wire_M_AXI_ARADDR  (araddr),
        .o_wire_M_AXI_ARLEN   (arlen),
        .o_wire_M_AXI_ARSIZE  (arsize),
        .o_wire_M_AXI_ARBURST (arburst),
        .o_wire_M_AXI_ARLOCK  (arlock),
        .o_wire_M_AXI_ARCACHE (arcache),
        .o_wire_M_AXI_ARPROT  (arprot),
        .o_wire_M_AXI_ARQOS   (arqos),
        .o_wire_M_AXI_ARVALID (arvalid),
        .i_wire_M_AXI_ARREADY (arready),
        .i_wire_M_AXI_RID     (rid),
        .i_wire_M_AXI_RDATA   (rdata),
        .i_wire_M_AXI_RRESP   (rresp),
        .i_wire_M_AXI_RLAST   (rlast),
        .i_wire_M_AXI_RVALID  (rvalid),
        .o_wire_M_AXI_RREADY  (rready)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5A;
    endfunction

    function automatic logic [31:0] ar_addr_at(input int i);
        return (i < ar_addr_log.size()) ? ar_addr_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] ar_len_at(input int i);
        return (i < ar_len_log.size()) ? 32'(ar_len_log[i]) : 32'hDEAD_DEAD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // AXI slave: memory returns word_at(address); drives at negedge, predicts acceptance.
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
        beat_k = 0; beats_total = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
                q_addr.delete(); q_len.delete(); ar_addr_log.delete(); ar_len_log.delete();
                beat_k = 0; beats_total = 0;
            end else begin
                if (q_addr.size() > 0) begin
                    rvalid = 1;
                    rdata  = word_at(q_addr[0] + 32'(beat_k * 4));
                    rlast  = (beat_k == int'(q_len[0])) || (beats_total == rlast_bad_at);
                    rresp  = (beats_total == rresp_bad_at) ? 2'b10 : 2'b00;
                    if (rready) begin
                        beats_total++;
                        if (beat_k == int'(q_len[0])) begin
                            beat_k = 0;
                            void'(q_addr.pop_front());
                            void'(q_len.pop_front());
                        end else begin
                            beat_k++;
                        end
                    end
                end else begin
                    rvalid = 0; rlast = 0; rresp = 0;
                end
                arready = ar_en;
                if (arvalid && ar_en) begin
                    q_addr.push_back(araddr); q_len.push_back(arlen);
                    ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
                end
            end
        end
    end

    // Consumer: pops on the active channel and records words.
    initial begin
        next = 0; other_nz = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rx.delete(); other_nz = 0; next = 0;
            end else begin
                next = next_en ? 4'hF : 4'h0;
                if (valid[cur_ch] && next[cur_ch]) rx.push_back(data[cur_ch*32 +: 32]);
                for (int k = 0; k < 4; k++)
                    if (k != cur_ch && data[k*32 +: 32] != 32'd0) other_nz++;
            end
        end
    end

    task automatic do_reset();
        resetn = 0; router = 0;
        repeat (3) @(negedge clk);
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic start(input int ch, input logic [31:0] a, input logic [31:0] l);
        cur_ch = ch;
        address[ch*32 +: 32] = a;
        length[ch*32 +: 32]  = l;
        router = 4'(1 << ch);
    endtask

    task automatic wait_end(input int budget, input string tag);
        int n;
        n = 0;
        while (!done && !error && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finished"}, 32'(done || error), 32'd1);
    endtask

    task automatic check_words(input string tag, input logic [31:0] base, input int n);
        chk({tag, " count"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++)
            chk($sformatf("%s word%0d", tag, i), rx[i], word_at(base + 32'(4 * i)));
    endtask

    initial begin
        resetn = 0; router = 0; address = '0; length = '0;
        do_reset();
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst etype", etype, 0);
        chk("rst arvalid", arvalid, 0);
        chk("rst arlen", arlen, 0);
        chk("rst rready", rready, 0);
        chk("rst valid", valid, 0);
        chk("rst data", 32'(data != '0), 0);

        // single aligned burst on channel 1
        start(1, 32'h1000_0000, 16);
        wait_end(300, "t1");
        chk("t1 done", done, 1);
        chk("t1 error", error, 0);
        chk("t1 ar count", ar_addr_log.size(), 1);
        chk("t1 araddr", ar_addr_at(0), 32'h1000_0000);
        chk("t1 arlen", ar_len_at(0), 15);
        check_words("t1", 32'h1000_0000, 16);
        chk("t1 other slices", other_nz, 0);

        // 1 KB boundary split: 4 beats then 6
        do_reset();
        start(0, 32'h1000_03F0, 10);
        wait_end(300, "t2");
        chk("t2 done", done, 1);
        chk("t2 ar count", ar_addr_log.size(), 2);
        chk("t2 araddr0", ar_addr_at(0), 32'h1000_03F0);
        chk("t2 arlen0", ar_len_at(0), 3);
        chk("t2 araddr1", ar_addr_at(1), 32'h1000_0400);
        chk("t2 arlen1", ar_len_at(1), 5);
        check_words("t2", 32'h1000_03F0, 10);

        // consumer backpressure with a 16-deep FIFO
        do_reset();
        next_en = 0;
        start(2, 32'h2000_0000, 64);
        repeat (200) @(negedge clk);
        chk("t3 held popped", rx.size(), 0);
        chk("t3 held ar count", ar_addr_log.size(), 1);
        chk("t3 held error", error, 0);
        chk("t3 held valid", valid, 4'b0100);
        chk("t3 held arvalid", arvalid, 0);
        next_en = 1;
        wait_end(800, "t3");
        chk("t3 done", done, 1);
        chk("t3 ar count", ar_addr_log.size(), 4);
        check_words("t3", 32'h2000_0000, 64);

        // setup errors
        do_reset();
        router = 4'b0011;
        wait_end(20, "t4");
        chk("t4 error", error, 1);
        chk("t4 etype", etype, 1);
        chk("t4 ar count", ar_addr_log.size(), 0);

        do_reset();
        start(0, 32'h1000_0002, 8);
        wait_end(20, "t5");
        chk("t5 etype", etype, 2);
        chk("t5 ar count", ar_addr_log.size(), 0);

        do_reset();
        start(0, 32'h1000_0000, 0);
        wait_end(20, "t6");
        chk("t6 etype", etype, 3);
        chk("t6 ar count", ar_addr_log.size(), 0);

        // RRESP error on the third beat
        do_reset();
        rresp_bad_at = 2;
        start(0, 32'h1000_0000, 8);
        wait_end(100, "t7");
        chk("t7 etype", etype, 6);
        chk("t7 rready", rready, 0);
        chk("t7 beats", beats_total, 3);
        chk("t7 valid", valid, 0);
        rresp_bad_at = -1;

        // early RLAST in a 4-beat burst
        do_reset();
        rlast_bad_at = 1;
        start(0, 32'h1000_0000, 4);
        wait_end(100, "t8");
        chk("t8 arlen", ar_len_at(0), 3);
        chk("t8 etype", etype, 7);
        rlast_bad_at = -1;

        // AR timeout
        do_reset();
        ar_en = 0;
        start(3, 32'h4000_0000, 8);
        repeat (200) @(negedge clk);
        chk("t9 early error", error, 0);
        chk("t9 arvalid held", arvalid, 1);
        chk("t9 araddr held", araddr, 32'h4000_0000);
        wait_end(100, "t9");
        chk("t9 etype", etype, 4);
        chk("t9 arvalid", arvalid, 0);
        ar_en = 1;

        // reset in the middle of the data phase
        do_reset();
        start(1, 32'h1000_0000, 16);
        begin
            int n;
            n = 0;
            while (beats_total < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t10 reached beat5", 32'(beats_total >= 5), 1);
        @(posedge clk);
        #2;
        resetn = 0;
        #1;
        chk("t10 rst valid", valid, 0);
        chk("t10 rst data", 32'(data != '0), 0);
        chk("t10 rst rready", rready, 0);
        chk("t10 rst arvalid", arvalid, 0);
        chk("t10 rst done", done, 0);
        chk("t10 rst error", error, 0);
        router = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("t10 fifo empty", valid, 0);
        start(0, 32'h3000_0100, 16);
        wait_end(300, "t10");
        chk("t10 done", done, 1);
        chk("t10 ar count", ar_addr_log.size(), 1);
        check_words("t10", 32'h3000_0100, 16);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
